// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite renderer: render queue -> sprite ROM -> double-buffered framebuffer.
// Optional BLITTER_CLEAR_EN: fill the new back bank with BG_COLOR after every bank swap.
module sprite_blitter #(
  parameter int                 FB_W      = 640,
  parameter int                 FB_H      = 480,
  parameter int                 PIXEL_W   = 24,
  parameter int                 SPR_AW    = 16,
  parameter int                 DIM_W     = 10,
  parameter logic [PIXEL_W-1:0] KEY_COLOR = 24'hFF00FF,
  parameter logic [7:0]         DO_RENDER = 8'hFF,
  parameter logic [PIXEL_W-1:0] BG_COLOR  = 24'h000000,
  parameter int                 FB_AW     = $clog2(FB_W*FB_H)
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [47:0]        cmd_data,
  output logic               cmd_pop,
  output logic [7:0]         desc_magic,
  input  logic               desc_valid,
  input  logic [SPR_AW-1:0]  desc_base,
  input  logic [DIM_W-1:0]   desc_w,
  input  logic [DIM_W-1:0]   desc_h,
  output logic [SPR_AW-1:0]  pix_addr,
  input  logic [PIXEL_W-1:0] pix_din,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [PIXEL_W-1:0] fb_din,
  output logic               fb_bank,
  input  logic               end_of_field,
  output logic               front_bank,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_DRAW   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
`ifdef BLITTER_CLEAR_EN
  localparam logic [2:0]       S_CLEAR    = 3'd5;
  localparam logic [FB_AW-1:0] L_CLR_LAST = FB_AW'(FB_W*FB_H-1);
`endif

  logic [2:0]        r_state;
  logic              r_cmd_pop;
  logic [7:0]        r_magic;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic              r_flip;
  logic [DIM_W-1:0]  r_w;
  logic [DIM_W-1:0]  r_h;
  logic [DIM_W-1:0]  r_cx;
  logic [DIM_W-1:0]  r_cy;
  logic [SPR_AW-1:0] r_row_base;
  logic [16:0]       r_x0;
  logic [16:0]       r_y0;
  logic              r_issue_d;
  logic [16:0]       r_sx_d;
  logic [16:0]       r_sy_d;
  logic              r_front;
  logic              r_frame_done;
`ifdef BLITTER_CLEAR_EN
  logic [FB_AW-1:0]  r_clr;
`endif

  logic              w_issue;
  logic              w_last_col;
  logic              w_last_row;
  logic [DIM_W-1:0]  w_off;
  logic [SPR_AW-1:0] w_pix_addr;
  logic              w_on_screen;
  logic [FB_AW-1:0]  w_lin;
  logic              w_unused;

  assign w_issue    = (r_state == S_DRAW);
  assign w_last_col = (r_cx == r_w - DIM_W'(1));
  assign w_last_row = (r_cy == r_h - DIM_W'(1));
  // Horizontal flip mirrors the column inside the current row only.
  assign w_off      = r_flip ? (r_w - DIM_W'(1) - r_cx) : r_cx;
  assign w_pix_addr = r_row_base + SPR_AW'(w_off);

  // Sign bit set means the coordinate went negative: clip, never wrap.
  assign w_on_screen = !r_sx_d[16] && (r_sx_d < 17'(FB_W)) &&
                       !r_sy_d[16] && (r_sy_d < 17'(FB_H));
  assign w_lin = FB_AW'(r_sy_d[15:0]) * FB_AW'(FB_W) + FB_AW'(r_sx_d[15:0]);

  assign cmd_pop    = r_cmd_pop;
  assign desc_magic = r_magic;
  assign pix_addr   = w_issue ? w_pix_addr : '0;
  assign fb_bank    = ~r_front;
  assign front_bank = r_front;
  assign busy       = (r_state != S_FETCH);
  assign frame_done = r_frame_done;

`ifdef BLITTER_CLEAR_EN
  assign fb_we    = (r_issue_d && w_on_screen && (pix_din != KEY_COLOR)) || (r_state == S_CLEAR);
  assign fb_addr  = r_issue_d ? w_lin : ((r_state == S_CLEAR) ? r_clr : '0);
  assign fb_din   = r_issue_d ? pix_din : ((r_state == S_CLEAR) ? BG_COLOR : '0);
  assign w_unused = &{1'b0, cmd_data[7:1]};
`else
  assign fb_we    = r_issue_d && w_on_screen && (pix_din != KEY_COLOR);
  assign fb_addr  = r_issue_d ? w_lin : '0;
  assign fb_din   = r_issue_d ? pix_din : '0;
  assign w_unused = &{1'b0, cmd_data[7:1], BG_COLOR};
`endif

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_cmd_pop    <= 1'b0;
      r_magic      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_flip       <= 1'b0;
      r_w          <= '0;
      r_h          <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_row_base   <= '0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_issue_d    <= 1'b0;
      r_sx_d       <= '0;
      r_sy_d       <= '0;
      r_front      <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef BLITTER_CLEAR_EN
      r_clr        <= '0;
`endif
    end else begin
      r_cmd_pop    <= 1'b0;
      r_frame_done <= 1'b0;
      r_issue_d    <= w_issue;
      if (w_issue) begin
        r_sx_d <= r_x0 + 17'(r_cx);
        r_sy_d <= r_y0 + 17'(r_cy);
      end
      case (r_state)
        S_FETCH: begin
          if (cmd_valid) begin
            r_cmd_pop <= 1'b1;
            r_magic   <= cmd_data[47:40];
            r_x       <= cmd_data[39:24];
            r_y       <= cmd_data[23:8];
            r_flip    <= cmd_data[0];
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_magic == DO_RENDER) begin
            r_state <= S_WAIT;
          end else if (!desc_valid || (desc_w == '0) || (desc_h == '0)) begin
            r_state <= S_FETCH;
          end else begin
            r_w        <= desc_w;
            r_h        <= desc_h;
            r_row_base <= desc_base;
            r_x0       <= {1'b0, r_x} - 17'(desc_w >> 1);
            r_y0       <= {1'b0, r_y} - 17'(desc_h >> 1);
            r_cx       <= '0;
            r_cy       <= '0;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_last_col) begin
            r_cx       <= '0;
            r_cy       <= r_cy + DIM_W'(1);
            r_row_base <= r_row_base + SPR_AW'(r_w);
            if (w_last_row) r_state <= S_DRAIN;
          end else begin
            r_cx <= r_cx + DIM_W'(1);
          end
        end
        S_DRAIN: r_state <= S_FETCH;
        S_WAIT: begin
          if (end_of_field) begin
            r_front      <= ~r_front;
            r_frame_done <= 1'b1;
`ifdef BLITTER_CLEAR_EN
            r_clr        <= '0;
            r_state      <= S_CLEAR;
`else
            r_state      <= S_FETCH;
`endif
          end
        end
`ifdef BLITTER_CLEAR_EN
        S_CLEAR: begin
          r_clr <= r_clr + FB_AW'(1);
          if (r_clr == L_CLR_LAST) r_state <= S_FETCH;
        end
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter (default build).
module tb_sprite_blitter;
  localparam int FB_AW = 19;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid;
  logic [47:0] cmd_data;
  logic        cmd_pop;
  logic [7:0]  desc_magic;
  logic        desc_valid;
  logic [15:0] desc_base;
  logic [9:0]  desc_w;
  logic [9:0]  desc_h;
  logic [15:0] pix_addr;
  logic [23:0] pix_din = 24'h0;
  logic        fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [23:0] fb_din;
  logic        fb_bank;
  logic        end_of_field = 1'b0;
  logic        front_bank;
  logic        busy;
  logic        frame_done;

  sprite_blitter dut (
    .clk50(clk50), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_pop(cmd_pop), .desc_magic(desc_magic), .desc_valid(desc_valid),
    .desc_base(desc_base), .desc_w(desc_w), .desc_h(desc_h), .pix_addr(pix_addr),
    .pix_din(pix_din), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .fb_bank(fb_bank), .end_of_field(end_of_field), .front_bank(front_bank),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  // Show-ahead command queue
  logic [47:0] cmd_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign cmd_valid = (rd_ptr != wr_ptr);
  assign cmd_data  = cmd_mem[rd_ptr];
  always @(posedge clk50) if (cmd_pop) rd_ptr <= rd_ptr + 1;

  // Descriptor table: magic 1 = 4x2 sprite at 0x100, magic 2 = zero width
  assign desc_valid = (desc_magic == 8'h01) || (desc_magic == 8'h02);
  assign desc_base  = 16'h0100;
  assign desc_w     = (desc_magic == 8'h01) ? 10'd4 : 10'd0;
  assign desc_h     = 10'd2;

  // Sync sprite ROM
  logic [15:0] key_addr = 16'hFFFF;
  always @(posedge clk50) pix_din <= (pix_addr == key_addr) ? 24'hFF00FF : {8'h5A, pix_addr};

  int n_wr = 0, n_pix = 0, n_pop = 0, n_fd = 0;
  logic [FB_AW-1:0] wr_addr [0:255];
  logic [23:0] wr_data [0:255];
  int wr_cyc [0:255];
  logic [15:0] pix_log [0:255];
  int pix_cyc [0:255];
  int pop_log [0:63];
  int idle_cyc = 0;

  always @(negedge clk50) begin
    if (fb_we && n_wr < 256) begin
      wr_addr[n_wr] = fb_addr; wr_data[n_wr] = fb_din; wr_cyc[n_wr] = cyc; n_wr++;
    end
    if (pix_addr != 16'h0 && n_pix < 256) begin
      pix_log[n_pix] = pix_addr; pix_cyc[n_pix] = cyc; n_pix++;
    end
    if (cmd_pop && n_pop < 64) begin pop_log[n_pop] = cyc; n_pop++; end
    if (frame_done) n_fd++;
  end

  function automatic logic [47:0] mk_cmd(input logic [7:0] m, input logic [15:0] x,
                                         input logic [15:0] y, input logic [7:0] f);
    return {m, x, y, f};
  endfunction

  function automatic int rom_of(input int a);
    return {8'h5A, a[15:0]};
  endfunction

  task automatic tick;
    @(negedge clk50); #1;
  endtask

  task automatic push(input logic [47:0] c);
    cmd_mem[wr_ptr] = c;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int p0, input int npops, input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (n_pop >= p0 + npops && !busy) break;
    end
    idle_cyc = cyc;
    checks++;
    if (k == 300) begin
      errors++;
      $display("FAIL %s_timeout: pops=%0d busy=%0b, required %0d pops and idle within 300 cycles",
               nm, n_pop - p0, busy, npops);
    end
  endtask

  task automatic test_reset;
    logic [72:0] got, exp;
    reset = 1'b1;
    repeat (3) tick();
    got = {cmd_pop, fb_we, fb_addr, fb_din, pix_addr, desc_magic, front_bank, fb_bank, busy, frame_done};
    exp = {1'b0, 1'b0, 19'd0, 24'd0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_outputs: got %h required %h", got, exp); end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cmd_pop !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%0b pop=%0b required 0 0", busy, cmd_pop);
    end
  endtask

  task automatic test_basic;
    int p0, w0, q0, pc, e;
    p0 = n_pop; w0 = n_wr; q0 = n_pix;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00)); pc = cyc;
    wait_done(p0, 1, "basic");
    checks++;
    if (pop_log[p0] !== pc + 1) begin errors++; $display("FAIL basic_pop_cycle: got %0d required %0d", pop_log[p0], pc + 1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (int'(pix_log[q0+i]) !== 32'h100 + i) begin
        errors++; $display("FAIL basic_pix_addr[%0d]: got %h required %h", i, pix_log[q0+i], 32'h100 + i);
      end
    end
    checks++;
    if (pix_cyc[q0] !== pop_log[p0] + 1) begin errors++; $display("FAIL basic_first_issue: got %0d required %0d", pix_cyc[q0], pop_log[p0] + 1); end
    checks++;
    if (n_wr - w0 !== 8) begin errors++; $display("FAIL basic_write_count: got %0d required 8", n_wr - w0); end
    for (int i = 0; i < 8; i++) begin
      e = (19 + i / 4) * 640 + 8 + (i % 4);
      checks++;
      if (int'(wr_addr[w0+i]) !== e || int'(wr_data[w0+i]) !== rom_of(32'h100 + i)) begin
        errors++; $display("FAIL basic_write[%0d]: got %0d/%h required %0d/%h", i, wr_addr[w0+i], wr_data[w0+i], e, rom_of(32'h100 + i));
      end
    end
    checks++;
    if (wr_cyc[w0] !== pop_log[p0] + 2) begin errors++; $display("FAIL basic_write_latency: got %0d required %0d", wr_cyc[w0], pop_log[p0] + 2); end
    checks++;
    if (wr_cyc[w0+7] - pc + 1 !== 11) begin errors++; $display("FAIL basic_cycle_count: got %0d required 11", wr_cyc[w0+7] - pc + 1); end
    checks++;
    if (idle_cyc - pop_log[p0] !== 10) begin errors++; $display("FAIL basic_idle: got %0d required 10", idle_cyc - pop_log[p0]); end
  endtask

  task automatic test_flip;
    int p0, w0, e;
    p0 = n_pop; w0 = n_wr;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h01));
    wait_done(p0, 1, "flip");
    checks++;
    if (n_wr - w0 !== 8) begin errors++; $display("FAIL flip_write_count: got %0d required 8", n_wr - w0); end
    for (int i = 0; i < 8; i++) begin
      e = rom_of(32'h100 + (i / 4) * 4 + (3 - i % 4));
      checks++;
      if (int'(wr_data[w0+i]) !== e || int'(wr_addr[w0+i]) !== (19 + i / 4) * 640 + 8 + (i % 4)) begin
        errors++; $display("FAIL flip_write[%0d]: got %0d/%h required %0d/%h", i, wr_addr[w0+i], wr_data[w0+i], (19 + i / 4) * 640 + 8 + (i % 4), e);
      end
    end
  endtask

  task automatic test_clip;
    int p0, w0;
    p0 = n_pop; w0 = n_wr;
    push(mk_cmd(8'h01, 16'd0, 16'd0, 8'h00));
    wait_done(p0, 1, "clip");
    checks++;
    if (n_wr - w0 !== 2) begin errors++; $display("FAIL clip_write_count: got %0d required 2", n_wr - w0); end
    checks++;
    if (wr_addr[w0] !== 19'd0 || int'(wr_data[w0]) !== rom_of(32'h106)) begin
      errors++; $display("FAIL clip_write0: got %0d/%h required 0/%h", wr_addr[w0], wr_data[w0], rom_of(32'h106));
    end
    checks++;
    if (wr_addr[w0+1] !== 19'd1 || int'(wr_data[w0+1]) !== rom_of(32'h107)) begin
      errors++; $display("FAIL clip_write1: got %0d/%h required 1/%h", wr_addr[w0+1], wr_data[w0+1], rom_of(32'h107));
    end
    checks++;
    if (idle_cyc - pop_log[p0] !== 10) begin errors++; $display("FAIL clip_cycle_count: got %0d required 10", idle_cyc - pop_log[p0]); end
  endtask

  task automatic test_key;
    int p0, w0;
    p0 = n_pop; w0 = n_wr;
    key_addr = 16'h0102;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    wait_done(p0, 1, "key");
    key_addr = 16'hFFFF;
    checks++;
    if (n_wr - w0 !== 7) begin errors++; $display("FAIL key_write_count: got %0d required 7", n_wr - w0); end
    checks++;
    if (int'(wr_addr[w0+1]) !== 12169 || wr_cyc[w0+1] !== pop_log[p0] + 3) begin
      errors++; $display("FAIL key_before: got %0d@%0d required 12169@%0d", wr_addr[w0+1], wr_cyc[w0+1], pop_log[p0] + 3);
    end
    checks++;
    if (int'(wr_addr[w0+2]) !== 12171 || wr_cyc[w0+2] !== pop_log[p0] + 5) begin
      errors++; $display("FAIL key_after: got %0d@%0d required 12171@%0d", wr_addr[w0+2], wr_cyc[w0+2], pop_log[p0] + 5);
    end
  endtask

  task automatic test_drop;
    int p0, w0, q0;
    p0 = n_pop; w0 = n_wr; q0 = n_pix;
    push(mk_cmd(8'h03, 16'd10, 16'd20, 8'h00));
    wait_done(p0, 1, "drop_invalid");
    checks++;
    if (idle_cyc - pop_log[p0] !== 1) begin errors++; $display("FAIL drop_invalid_idle: got %0d required 1", idle_cyc - pop_log[p0]); end
    push(mk_cmd(8'h02, 16'd10, 16'd20, 8'h00));
    wait_done(p0 + 1, 1, "drop_zero_w");
    checks++;
    if (idle_cyc - pop_log[p0+1] !== 1) begin errors++; $display("FAIL drop_zero_w_idle: got %0d required 1", idle_cyc - pop_log[p0+1]); end
    checks++;
    if (n_wr !== w0 || n_pix !== q0) begin errors++; $display("FAIL drop_activity: writes=%0d issues=%0d required 0 0", n_wr - w0, n_pix - q0); end
  endtask

  task automatic test_back_to_back;
    int p0, w0;
    p0 = n_pop; w0 = n_wr;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    push(mk_cmd(8'h01, 16'd100, 16'd50, 8'h01));
    wait_done(p0, 2, "b2b");
    checks++;
    if (pop_log[p0+1] - pop_log[p0] !== 11) begin errors++; $display("FAIL b2b_pop_spacing: got %0d required 11", pop_log[p0+1] - pop_log[p0]); end
    checks++;
    if (n_wr - w0 !== 16) begin errors++; $display("FAIL b2b_write_count: got %0d required 16", n_wr - w0); end
    checks++;
    if (int'(wr_addr[w0+8]) !== 49 * 640 + 98 || int'(wr_data[w0+8]) !== rom_of(32'h103)) begin
      errors++; $display("FAIL b2b_second_first: got %0d/%h required %0d/%h", wr_addr[w0+8], wr_data[w0+8], 49 * 640 + 98, rom_of(32'h103));
    end
    checks++;
    if (wr_cyc[w0+15] !== pop_log[p0+1] + 9) begin errors++; $display("FAIL b2b_last_write: got %0d required %0d", wr_cyc[w0+15], pop_log[p0+1] + 9); end
  endtask

  task automatic test_eof_ignored;
    int p0, q0, f0, k;
    f0 = n_fd;
    end_of_field = 1'b1; tick(); end_of_field = 1'b0; tick();
    checks++;
    if (front_bank !== 1'b0 || n_fd !== f0) begin errors++; $display("FAIL eof_idle: front=%0b pulses=%0d required 0 0", front_bank, n_fd - f0); end
    p0 = n_pop; q0 = n_pix;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    for (k = 0; k < 20; k++) begin tick(); if (n_pix > q0) break; end
    end_of_field = 1'b1; tick(); end_of_field = 1'b0;
    wait_done(p0, 1, "eof_draw");
    checks++;
    if (front_bank !== 1'b0 || n_fd !== f0) begin errors++; $display("FAIL eof_draw: front=%0b pulses=%0d required 0 0", front_bank, n_fd - f0); end
  endtask

  task automatic test_do_render;
    int p0, f0, k, swap_cyc;
    p0 = n_pop; f0 = n_fd;
    push(mk_cmd(8'hFF, 16'd0, 16'd0, 8'h00));
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    for (k = 0; k < 10; k++) begin tick(); if (n_pop > p0) break; end
    checks++;
    if (k == 10) begin errors++; $display("FAIL render_pop_timeout: pops=%0d required 1", n_pop - p0); end
    repeat (100) tick();
    checks++;
    if (n_pop - p0 !== 1 || busy !== 1'b1 || front_bank !== 1'b0) begin
      errors++; $display("FAIL render_wait: pops=%0d busy=%0b front=%0b required 1 1 0", n_pop - p0, busy, front_bank);
    end
    end_of_field = 1'b1; tick(); end_of_field = 1'b0;
    swap_cyc = cyc;
    checks++;
    if (front_bank !== 1'b1 || fb_bank !== 1'b0 || frame_done !== 1'b1) begin
      errors++; $display("FAIL render_swap: front=%0b fb_bank=%0b done=%0b required 1 0 1", front_bank, fb_bank, frame_done);
    end
    wait_done(p0 + 1, 1, "render_next");
    checks++;
    if (n_fd - f0 !== 1) begin errors++; $display("FAIL render_done_pulse: got %0d cycles required 1", n_fd - f0); end
    checks++;
    if (pop_log[p0+1] !== swap_cyc + 1) begin errors++; $display("FAIL render_next_pop: got %0d required %0d", pop_log[p0+1], swap_cyc + 1); end
  endtask

  task automatic test_reset_mid_draw;
    int p1, q0, w0, k;
    logic [72:0] got, exp;
    q0 = n_pix;
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    for (k = 0; k < 20; k++) begin tick(); if (n_pix > q0 + 2) break; end
    checks++;
    if (k == 20) begin errors++; $display("FAIL rst_draw_timeout: issues=%0d required 3", n_pix - q0); end
    reset = 1'b1; #1;
    got = {cmd_pop, fb_we, fb_addr, fb_din, pix_addr, desc_magic, front_bank, fb_bank, busy, frame_done};
    exp = {1'b0, 1'b0, 19'd0, 24'd0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_draw_outputs: got %h required %h", got, exp); end
    push(mk_cmd(8'h01, 16'd10, 16'd20, 8'h00));
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cmd_pop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_hold[%0d]: pop=%0b busy=%0b required 0 0", i, cmd_pop, busy); end
    end
    p1 = n_pop; w0 = n_wr;
    reset = 1'b0;
    wait_done(p1, 1, "rst_resume");
    checks++;
    if (n_pop - p1 !== 1 || n_wr - w0 !== 8 || int'(wr_addr[w0]) !== 12168) begin
      errors++; $display("FAIL rst_resume: pops=%0d writes=%0d first=%0d required 1 8 12168", n_pop - p1, n_wr - w0, wr_addr[w0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_clip();
    test_key();
    test_drop();
    test_back_to_back();
    test_eof_ignored();
    test_do_render();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
